mfp_ahb_bot_hub: RTL and testbench

- AHB-Lite slave that connects N_BOTS Rojobot channels to the MIPS core.
- Generalises the single-bot H_BOT_INFO / H_BOT_UPDATE_SYNC / H_BOT_CTRL / H_INT_ACK interface into a parametrised, multi-channel block with the following per channel:
  - info snapshot;
  - pending flag;
  - overrun counter;
  - interrupt enable.
- Produces one aggregated interrupt line for SI_Int. Sits beside the GPIO/7-seg slaves on the AHB decoder.

---
 rtl/mfp_ahb_bot_hub_pkg.sv | 43 ++++
 rtl/mfp_ahb_bot_hub_if.sv | 24 ++
 rtl/mfp_bot_chan.sv | 91 +++++++++
 rtl/mfp_ahb_bot_hub.sv | 147 ++++++++++++++
 tb/tb_mfp_ahb_bot_hub.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfp_ahb_bot_hub_pkg.sv
// Shared constants and types for the multi-channel Rojobot AHB hub.
// Byte offsets are relative to the hub's base address on the AHB decoder.
package mfp_ahb_bot_hub_pkg;

    // Each channel owns a 16-byte window starting at 0x00
    localparam int BOT_CHAN_STRIDE = 'h10;
    localparam int CHAN_WORD_SHIFT = $clog2(BOT_CHAN_STRIDE / 4);

    // Field offsets inside a channel window
    localparam logic [7:0] BOT_INFO_OFF  = 8'h00;
    localparam logic [7:0] BOT_CTRL_OFF  = 8'h04;
    localparam logic [7:0] BOT_OVF_OFF   = 8'h08;

    // Hub-wide registers above the channel windows
    localparam logic [7:0] BOT_PEND_ADDR = 8'h80;
    localparam logic [7:0] BOT_EN_ADDR   = 8'h84;
    localparam logic [7:0] BOT_ACK_ADDR  = 8'h88;

    typedef enum logic [1:0] {
        FLD_INFO,
        FLD_CTRL,
        FLD_OVF,
        FLD_NONE
    } chan_field_e;

    // Registered AHB address phase
    typedef struct packed {
        logic       wr_en;
        logic       rd_en;
        logic [5:0] addr;   // word address (HADDR[7:2])
    } ahb_aphase_t;

    // Which field of a channel window a word address selects
    function automatic chan_field_e chan_field(input logic [5:0] waddr);
        chan_field_e fld;
        if (waddr[1:0] == BOT_INFO_OFF[3:2])      fld = FLD_INFO;
        else if (waddr[1:0] == BOT_CTRL_OFF[3:2]) fld = FLD_CTRL;
        else if (waddr[1:0] == BOT_OVF_OFF[3:2])  fld = FLD_OVF;
        else                                      fld = FLD_NONE;
        return fld;
    endfunction

endpackage

// File: rtl/mfp_ahb_bot_hub_if.sv
// AHB-Lite slave-side bus bundle for the bot hub (clock/reset stay separate).
interface mfp_ahb_bot_hub_if;

    logic        HSEL;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/mfp_bot_chan.sv
// One Rojobot channel: update synchroniser and edge detect, info snapshot,
// pending flag, saturating overrun counter, CTRL register and ack pulse.
module mfp_bot_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int OVF_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bot_update_i,
    input  logic [31:0]      bot_info_i,
    input  logic             ctrl_we_i,
    input  logic [7:0]       ctrl_wdata_i,
    input  logic             ovf_clr_i,
    input  logic             ack_i,
    output logic [31:0]      info_o,
    output logic [7:0]       ctrl_o,
    output logic [OVF_W-1:0] ovf_o,
    output logic             pending_o,
    output logic             ack_pulse_o
);

    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   event_w;

    logic [31:0]            snap_q;
    logic                   pending_q, pending_d;
    logic [OVF_W-1:0]       ovf_q, ovf_d;
    logic [7:0]             ctrl_q;
    logic                   ack_q;

    // Bring BOT_UPDATE into the HCLK domain and keep the previous synchronised level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; a blocking
            // shift here would collapse the synchroniser into a single stage.
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bot_update_i};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign event_w = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

    // Pending and overrun next state: a new event beats an ack, an OVF write beats an event
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (event_w)
            pending_d = 1'b1;
        else if (ack_i)
            pending_d = 1'b0;
        if (ovf_clr_i)
            ovf_d = '0;
        else if (event_w && pending_q && (ovf_q != OVF_MAX))
            ovf_d = ovf_q + OVF_W'(1);
    end

    // Channel state registers; the ack pulse is the registered ACK write bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the snapshot is an ordinary register, not a RAM, so it is
            // reset with everything else and INFO reads 0 straight after reset.
            snap_q    <= '0;
            pending_q <= 1'b0;
            ovf_q     <= '0;
            ctrl_q    <= '0;
            ack_q     <= 1'b0;
        end else begin
            if (event_w)
                snap_q <= bot_info_i;
            if (ctrl_we_i)
                ctrl_q <= ctrl_wdata_i;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ack_q     <= ack_i;
        end
    end

    assign info_o      = snap_q;
    assign ctrl_o      = ctrl_q;
    assign ovf_o       = ovf_q;
    assign pending_o   = pending_q;
    assign ack_pulse_o = ack_q;

endmodule

// File: rtl/mfp_ahb_bot_hub.sv
// AHB-Lite slave hub for N_BOTS Rojobot channels: AHB phase registers, address
// decode, read mux, interrupt enable register and the aggregated IRQ.
module mfp_ahb_bot_hub
    import mfp_ahb_bot_hub_pkg::*;
#(
    parameter int N_BOTS      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int OVF_W       = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    mfp_ahb_bot_hub_if.slave      bus,
    input  logic [32*N_BOTS-1:0]  BOT_INFO,
    input  logic [N_BOTS-1:0]     BOT_UPDATE,
    output logic [8*N_BOTS-1:0]   BOT_CTRL,
    output logic [N_BOTS-1:0]     BOT_INT_ACK,
    output logic                  IRQ
);

    ahb_aphase_t        aph_q, aph_d;
    logic               in_chan;
    logic [2:0]         chan_sel;
    chan_field_e        fld;
    logic               is_pend, is_en, is_ack;

    logic [N_BOTS-1:0]  ctrl_we, ovf_clr, ack_set;
    logic [N_BOTS-1:0]  pend_w;
    logic [31:0]        info_w [N_BOTS];
    logic [OVF_W-1:0]   ovf_w  [N_BOTS];

    logic [N_BOTS-1:0]  en_q;
    logic               irq_q;
    logic [31:0]        rdata_w;

    // HSIZE is ignored (all accesses are 32-bit); HTRANS[0] and byte lanes are not needed
    logic unused_bus;
    assign unused_bus = ^{bus.HSIZE, bus.HTRANS[0], bus.HADDR[1:0], bus.HWDATA[31:8]};

    assign bus.HREADY = 1'b1;
    assign bus.HRESP  = 1'b0;

    // Capture the address phase of an active transfer; idle cycles drop the enables
    always_comb begin
        aph_d       = aph_q;
        aph_d.wr_en = 1'b0;
        aph_d.rd_en = 1'b0;
        if (bus.HSEL && bus.HTRANS[1] && bus.HREADY) begin
            aph_d.wr_en = bus.HWRITE;
            aph_d.rd_en = ~bus.HWRITE;
            aph_d.addr  = bus.HADDR[7:2];
        end
    end

    // Address-phase register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            aph_q <= '0;
        else
            aph_q <= aph_d;
    end

    // Decode of the registered word address
    assign in_chan  = ({aph_q.addr, 2'b00} < BOT_PEND_ADDR);
    assign chan_sel = 3'(aph_q.addr >> CHAN_WORD_SHIFT);
    assign fld      = chan_field(aph_q.addr);
    assign is_pend  = ({aph_q.addr, 2'b00} == BOT_PEND_ADDR);
    assign is_en    = ({aph_q.addr, 2'b00} == BOT_EN_ADDR);
    assign is_ack   = ({aph_q.addr, 2'b00} == BOT_ACK_ADDR);

    // Data-phase write strobes towards the channels
    always_comb begin
        ctrl_we = '0;
        ovf_clr = '0;
        ack_set = '0;
        for (int i = 0; i < N_BOTS; i++) begin
            if (aph_q.wr_en && in_chan && (chan_sel == 3'(i))) begin
                ctrl_we[i] = (fld == FLD_CTRL);
                ovf_clr[i] = (fld == FLD_OVF);
            end
        end
        if (aph_q.wr_en && is_ack)
            ack_set = bus.HWDATA[N_BOTS-1:0];
    end

    generate
        for (genvar g = 0; g < N_BOTS; g++) begin : g_chan
            mfp_bot_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .OVF_W       (OVF_W)
            ) u_chan (
                .clk          (HCLK),
                .rst_n        (HRESETn),
                .bot_update_i (BOT_UPDATE[g]),
                .bot_info_i   (BOT_INFO[32*g +: 32]),
                .ctrl_we_i    (ctrl_we[g]),
                .ctrl_wdata_i (bus.HWDATA[7:0]),
                .ovf_clr_i    (ovf_clr[g]),
                .ack_i        (ack_set[g]),
                .info_o       (info_w[g]),
                .ctrl_o       (BOT_CTRL[8*g +: 8]),
                .ovf_o        (ovf_w[g]),
                .pending_o    (pend_w[g]),
                .ack_pulse_o  (BOT_INT_ACK[g])
            );
        end
    endgenerate

    // Interrupt enable register and registered IRQ aggregate
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (aph_q.wr_en && is_en)
                en_q <= bus.HWDATA[N_BOTS-1:0];
            irq_q <= |(pend_w & en_q);
        end
    end

    assign IRQ = irq_q;

    // Read mux, driven only during a read data phase; unmapped words read 0
    always_comb begin
        rdata_w = '0;
        if (aph_q.rd_en) begin
            if (in_chan) begin
                for (int i = 0; i < N_BOTS; i++) begin
                    if (chan_sel == 3'(i)) begin
                        case (fld)
                            FLD_INFO: rdata_w = info_w[i];
                            FLD_CTRL: rdata_w = {24'b0, BOT_CTRL[8*i +: 8]};
                            FLD_OVF:  rdata_w = 32'(ovf_w[i]);
                            default:  rdata_w = '0;
                        endcase
                    end
                end
            end else if (is_pend) begin
                rdata_w = 32'(pend_w);
            end else if (is_en) begin
                rdata_w = 32'(en_q);
            end
        end
    end

    assign bus.HRDATA = rdata_w;

endmodule

// File: tb/tb_mfp_ahb_bot_hub.sv
// Self-checking bench for mfp_ahb_bot_hub: directed scenarios plus a randomized
// sequence, all compared against a register-level model of the hub.
module tb_mfp_ahb_bot_hub;
    import mfp_ahb_bot_hub_pkg::*;

    localparam int N       = 4;
    localparam int SYNC    = 2;
    localparam int OVF_W   = 2;
    localparam int OVF_MAX = (1 << OVF_W) - 1;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic [32*N-1:0]  BOT_INFO = '0;
    logic [N-1:0]     BOT_UPDATE = '0;
    logic [8*N-1:0]   BOT_CTRL;
    logic [N-1:0]     BOT_INT_ACK;
    logic             IRQ;

    mfp_ahb_bot_hub_if bus ();

    mfp_ahb_bot_hub #(
        .N_BOTS      (N),
        .SYNC_STAGES (SYNC),
        .OVF_W       (OVF_W)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .bus         (bus),
        .BOT_INFO    (BOT_INFO),
        .BOT_UPDATE  (BOT_UPDATE),
        .BOT_CTRL    (BOT_CTRL),
        .BOT_INT_ACK (BOT_INT_ACK),
        .IRQ         (IRQ)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    // Register-level model
    logic [31:0] m_snap [N];
    bit          m_pend [N];
    int          m_ovf  [N];
    logic [7:0]  m_ctrl [N];
    logic [N-1:0] m_en;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_snap[i] = '0; m_pend[i] = 0; m_ovf[i] = 0; m_ctrl[i] = '0;
        end
        m_en = '0;
    endtask

    task automatic model_event(input int ch, input logic [31:0] info);
        if (m_pend[ch] && m_ovf[ch] < OVF_MAX) m_ovf[ch]++;
        m_pend[ch] = 1;
        m_snap[ch] = info;
    endtask

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        int ch  = int'(a) / 16;
        int off = int'(a) % 16;
        logic [31:0] v = '0;
        if (a < 8'h80) begin
            if (ch < N) begin
                if (off == 0)      v = m_snap[ch];
                else if (off == 4) v = {24'b0, m_ctrl[ch]};
                else if (off == 8) v = 32'(m_ovf[ch]);
            end
        end else if (a == 8'h80) begin
            for (int i = 0; i < N; i++) v[i] = m_pend[i];
        end else if (a == 8'h84) begin
            v = 32'(m_en);
        end
        return v;
    endfunction

    function automatic logic model_irq();
        logic r = 1'b0;
        for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [8*N-1:0] model_ctrl();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = m_ctrl[i];
        return v;
    endfunction

    // Bus helpers: every helper starts and ends 1 ns after a rising edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_addr(input logic [7:0] a, input logic w);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = w;
        bus.HADDR = a; bus.HSIZE = 3'b010;
    endtask

    task automatic set_idle();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
        set_addr(a, 1'b1);
        tick();
        set_idle();
        bus.HWDATA = d;
        tick();
    endtask

    task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
        set_addr(a, 1'b0);
        tick();
        set_idle();
        d = bus.HRDATA;
    endtask

    task automatic pulse_update(input int ch, input logic [31:0] info);
        BOT_INFO[32*ch +: 32] = info;
        BOT_UPDATE[ch] = 1'b1;
        repeat (SYNC + 2) tick();
        BOT_UPDATE[ch] = 1'b0;
        repeat (SYNC + 2) tick();
        model_event(ch, info);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [7:0]  a;
        HRESETn = 1'b0;
        repeat (3) tick();
        checks++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin failures++; $display("FAIL rst_hready_hresp got=%b exp=10", {bus.HREADY, bus.HRESP}); end
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", IRQ); end
        checks++; if (BOT_CTRL !== '0) begin failures++; $display("FAIL rst_bot_ctrl got=%h exp=0", BOT_CTRL); end
        checks++; if (BOT_INT_ACK !== '0) begin failures++; $display("FAIL rst_int_ack got=%b exp=0", BOT_INT_ACK); end
        checks++; if (bus.HRDATA !== '0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", bus.HRDATA); end
        HRESETn = 1'b1;
        model_reset();
        tick();
        for (int k = 0; k < 3*N + 3; k++) begin
            a = (k < 3*N) ? 8'((k/3)*16 + (k%3)*4) : 8'(8'h80 + (k - 3*N)*4);
            ahb_read(a, d);
            checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_read addr=%h got=%h exp=0", a, d); end
        end
    endtask

    task automatic test_update_irq();
        logic [31:0] d;
        BOT_INFO[64 +: 32] = 32'hDEADBEEF;
        BOT_UPDATE[2] = 1'b1;
        repeat (SYNC - 1) tick();
        set_addr(BOT_PEND_ADDR, 1'b0);
        tick();
        checks++; if (bus.HRDATA !== 32'h0) begin failures++; $display("FAIL pend_early got=%h exp=0", bus.HRDATA); end
        set_addr(BOT_PEND_ADDR, 1'b0);
        tick();
        set_idle();
        checks++; if (bus.HRDATA !== 32'h4) begin failures++; $display("FAIL pend_set got=%h exp=4", bus.HRDATA); end
        model_event(2, 32'hDEADBEEF);
        ahb_read(8'h20, d);
        checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL info2 got=%h exp=deadbeef", d); end
        ahb_write(BOT_EN_ADDR, 32'h4);
        m_en = 4'h4;
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL irq_lag got=%b exp=0", IRQ); end
        tick();
        checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", IRQ); end
        ahb_write(BOT_ACK_ADDR, 32'h4);
        m_pend[2] = 0;
        checks++; if (BOT_INT_ACK !== 4'b0100) begin failures++; $display("FAIL ack_pulse got=%b exp=0100", BOT_INT_ACK); end
        checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", IRQ); end
        tick();
        checks++; if (BOT_INT_ACK !== 4'b0000) begin failures++; $display("FAIL ack_width got=%b exp=0000", BOT_INT_ACK); end
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", IRQ); end
        ahb_read(BOT_PEND_ADDR, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL pend_clear got=%h exp=0", d); end
        BOT_UPDATE[2] = 1'b0;
        repeat (SYNC + 2) tick();
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        repeat (3) pulse_update(1, $urandom);
        ahb_read(8'h18, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL ovf_three got=%h exp=2", d); end
        repeat (2) pulse_update(1, $urandom);
        ahb_read(8'h18, d);
        checks++; if (d !== 32'd3 || d !== exp_read(8'h18)) begin failures++; $display("FAIL ovf_saturate got=%h exp=3", d); end
        ahb_write(8'h18, $urandom);
        m_ovf[1] = 0;
        ahb_read(8'h18, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL ovf_clear got=%h exp=0", d); end
        ahb_read(8'h10, d);
        checks++; if (d !== exp_read(8'h10)) begin failures++; $display("FAIL ovf_info got=%h exp=%h", d, exp_read(8'h10)); end
        ahb_write(BOT_ACK_ADDR, 32'h2);
        m_pend[1] = 0;
    endtask

    task automatic test_same_cycle();
        logic [31:0] d, info, old;
        pulse_update(0, $urandom);
        // Event and ACK commit on the same edge
        info = $urandom;
        BOT_INFO[0 +: 32] = info;
        BOT_UPDATE[0] = 1'b1;
        repeat (SYNC - 1) tick();
        set_addr(BOT_ACK_ADDR, 1'b1);
        tick();
        set_idle();
        bus.HWDATA = 32'h1;
        tick();
        model_event(0, info);
        checks++; if (BOT_INT_ACK !== 4'b0001) begin failures++; $display("FAIL sc_ack_pulse got=%b exp=0001", BOT_INT_ACK); end
        tick();
        checks++; if (BOT_INT_ACK !== 4'b0000) begin failures++; $display("FAIL sc_ack_width got=%b exp=0000", BOT_INT_ACK); end
        BOT_UPDATE[0] = 1'b0;
        repeat (SYNC + 2) tick();
        ahb_read(BOT_PEND_ADDR, d);
        checks++; if (d[0] !== 1'b1) begin failures++; $display("FAIL sc_pend_kept got=%b exp=1", d[0]); end
        ahb_read(8'h08, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL sc_ovf got=%h exp=1", d); end
        ahb_read(8'h00, d);
        checks++; if (d !== info) begin failures++; $display("FAIL sc_snap got=%h exp=%h", d, info); end
        // INFO read during the event cycle sees the previous snapshot
        old  = m_snap[0];
        info = $urandom;
        BOT_INFO[0 +: 32] = info;
        BOT_UPDATE[0] = 1'b1;
        repeat (SYNC - 1) tick();
        set_addr(8'h00, 1'b0);
        tick();
        set_idle();
        checks++; if (bus.HRDATA !== old) begin failures++; $display("FAIL sc_read_old got=%h exp=%h", bus.HRDATA, old); end
        tick();
        model_event(0, info);
        BOT_UPDATE[0] = 1'b0;
        repeat (SYNC + 2) tick();
        ahb_read(8'h00, d);
        checks++; if (d !== info) begin failures++; $display("FAIL sc_read_new got=%h exp=%h", d, info); end
        // Event and OVF write on the same edge: the clear wins
        info = $urandom;
        BOT_INFO[0 +: 32] = info;
        BOT_UPDATE[0] = 1'b1;
        repeat (SYNC - 1) tick();
        set_addr(8'h08, 1'b1);
        tick();
        set_idle();
        bus.HWDATA = $urandom;
        tick();
        model_event(0, info);
        m_ovf[0] = 0;
        BOT_UPDATE[0] = 1'b0;
        repeat (SYNC + 2) tick();
        ahb_read(8'h08, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL sc_ovf_clear got=%h exp=0", d); end
        ahb_write(BOT_ACK_ADDR, 32'h1);
        m_pend[0] = 0;
    endtask

    task automatic test_ctrl();
        logic [31:0] d, r;
        for (int ch = 0; ch < 3; ch++) begin
            r = $urandom;
            ahb_write(8'(ch*16 + 4), r);
            m_ctrl[ch] = r[7:0];
        end
        ahb_write(8'h34, 32'hFFFFFFA5);
        m_ctrl[3] = 8'hA5;
        checks++; if (BOT_CTRL[31:24] !== 8'hA5) begin failures++; $display("FAIL ctrl3_pin got=%h exp=a5", BOT_CTRL[31:24]); end
        ahb_read(8'h34, d);
        checks++; if (d !== 32'h000000A5) begin failures++; $display("FAIL ctrl3_read got=%h exp=000000a5", d); end
        checks++; if (BOT_CTRL !== model_ctrl()) begin failures++; $display("FAIL ctrl_others got=%h exp=%h", BOT_CTRL, model_ctrl()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        v = $urandom;
        set_addr(8'h04, 1'b1);
        tick();
        set_addr(8'h04, 1'b0);
        bus.HWDATA = v;
        tick();
        set_idle();
        m_ctrl[0] = v[7:0];
        checks++; if (bus.HRDATA !== {24'b0, v[7:0]}) begin failures++; $display("FAIL b2b_read got=%h exp=%h", bus.HRDATA, {24'b0, v[7:0]}); end
        checks++; if (BOT_CTRL[7:0] !== v[7:0]) begin failures++; $display("FAIL b2b_pin got=%h exp=%h", BOT_CTRL[7:0], v[7:0]); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [7:0]  a;
        ahb_write(8'h40, $urandom);
        ahb_write(8'h8C, $urandom);
        ahb_write(8'h0C, $urandom);
        ahb_write(8'h00, $urandom);
        ahb_write(BOT_PEND_ADDR, 32'hF);
        ahb_read(8'h40, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmap_40 got=%h exp=0", d); end
        ahb_read(8'h8C, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmap_8c got=%h exp=0", d); end
        ahb_read(BOT_ACK_ADDR, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ack_read got=%h exp=0", d); end
        for (int k = 0; k < 3*N + 2; k++) begin
            a = (k < 3*N) ? 8'((k/3)*16 + (k%3)*4) : 8'(8'h80 + (k - 3*N)*4);
            ahb_read(a, d);
            checks++; if (d !== exp_read(a)) begin failures++; $display("FAIL unmap_state addr=%h got=%h exp=%h", a, d, exp_read(a)); end
        end
        checks++; if (BOT_CTRL !== model_ctrl()) begin failures++; $display("FAIL unmap_ctrl got=%h exp=%h", BOT_CTRL, model_ctrl()); end
    endtask

    task automatic test_random();
        logic [31:0] d, r;
        logic [7:0]  a;
        int op, ch, k;
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 5);
            ch = $urandom_range(0, N - 1);
            r  = $urandom;
            case (op)
                0: pulse_update(ch, r);
                1: begin ahb_write(8'(ch*16 + 4), r); m_ctrl[ch] = r[7:0]; end
                2: begin ahb_write(BOT_EN_ADDR, r); m_en = r[N-1:0]; end
                3: begin
                    ahb_write(BOT_ACK_ADDR, r);
                    checks++; if (BOT_INT_ACK !== r[N-1:0]) begin failures++; $display("FAIL rand_ack got=%b exp=%b", BOT_INT_ACK, r[N-1:0]); end
                    for (int j = 0; j < N; j++) if (r[j]) m_pend[j] = 0;
                end
                4: begin ahb_write(8'(ch*16 + 8), r); m_ovf[ch] = 0; end
                default: begin
                    k = $urandom_range(0, 3*N + 2);
                    a = (k < 3*N) ? 8'((k/3)*16 + (k%3)*4) : 8'(8'h80 + (k - 3*N)*4);
                    ahb_read(a, d);
                    checks++; if (d !== exp_read(a)) begin failures++; $display("FAIL rand_read addr=%h got=%h exp=%h", a, d, exp_read(a)); end
                end
            endcase
            tick();
            checks++; if (IRQ !== model_irq()) begin failures++; $display("FAIL rand_irq iter=%0d got=%b exp=%b", it, IRQ, model_irq()); end
            checks++; if (BOT_CTRL !== model_ctrl()) begin failures++; $display("FAIL rand_ctrl iter=%0d got=%h exp=%h", it, BOT_CTRL, model_ctrl()); end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        ahb_write(BOT_EN_ADDR, 32'hF);
        set_addr(8'h04, 1'b1);
        tick();
        set_idle();
        bus.HWDATA = 32'h5A;
        #2 HRESETn = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
        model_reset();
        checks++; if (BOT_CTRL !== '0) begin failures++; $display("FAIL midrst_ctrl got=%h exp=0", BOT_CTRL); end
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL midrst_irq got=%b exp=0", IRQ); end
        tick();
        ahb_write(8'h04, 32'h3C);
        m_ctrl[0] = 8'h3C;
        checks++; if (BOT_CTRL[7:0] !== 8'h3C) begin failures++; $display("FAIL midrst_first_wr got=%h exp=3c", BOT_CTRL[7:0]); end
        ahb_read(8'h04, d);
        checks++; if (d !== 32'h3C) begin failures++; $display("FAIL midrst_readback got=%h exp=3c", d); end
        ahb_read(BOT_EN_ADDR, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_enable got=%h exp=0", d); end
    endtask

    initial begin
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HADDR  = '0;
        bus.HWDATA = '0;
        model_reset();
        test_reset();
        test_update_irq();
        test_overrun();
        test_same_cycle();
        test_ctrl();
        test_back_to_back();
        test_unmapped();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
